// File: rtl/fp_mul_pipe_pkg.sv
// Shared types for the pipelined IEEE-754 multiplier: operand classes, the
// special-result selector and the special-case priority function.
package fp_mul_pipe_pkg;

    typedef enum logic [1:0] {
        CLS_ZERO = 2'd0,
        CLS_NORM = 2'd1,
        CLS_INF  = 2'd2,
        CLS_NAN  = 2'd3
    } fp_class_e;

    typedef enum logic [1:0] {
        SP_NONE = 2'd0,
        SP_NAN  = 2'd1,
        SP_INF  = 2'd2,
        SP_ZERO = 2'd3
    } fp_special_e;

    localparam int FLAG_W = 4;

    // NaN beats inf*0, which beats inf*finite, which beats zero*finite.
    function automatic fp_special_e special_sel(input logic [1:0] ca, input logic [1:0] cb);
        if (ca == CLS_NAN || cb == CLS_NAN ||
            (ca == CLS_INF && cb == CLS_ZERO) || (ca == CLS_ZERO && cb == CLS_INF))
            return SP_NAN;
        if (ca == CLS_INF || cb == CLS_INF)
            return SP_INF;
        if (ca == CLS_ZERO || cb == CLS_ZERO)
            return SP_ZERO;
        return SP_NONE;
    endfunction

endpackage

// File: rtl/fp_mul_pipe_unpack.sv
// Combinational operand unpack: field split, classification and hidden-bit
// insertion. Subnormals classify as zero (denormals-are-zero).
module fp_mul_pipe_unpack
    import fp_mul_pipe_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic [EXP_W+MAN_W:0] word,
    output logic                 sign,
    output logic [EXP_W-1:0]     exp,
    output logic [MAN_W:0]       sig,
    output logic [1:0]           cls
);

    always_comb begin
        sign = word[EXP_W+MAN_W];
        exp  = word[EXP_W+MAN_W-1:MAN_W];
        sig  = '0;
        cls  = CLS_NORM;
        if (exp == '0) begin
            cls = CLS_ZERO;
        end else if (&exp) begin
            cls = (word[MAN_W-1:0] != '0) ? CLS_NAN : CLS_INF;
        end else begin
            sig = {1'b1, word[MAN_W-1:0]};
        end
    end

endmodule

// File: rtl/fp_mul_pipe.sv
// Pipelined IEEE-754 multiplier (operand register + 3 compute stages), RNE, DAZ/FTZ,
// global stall on backpressure. Define FP_MUL_FLAGS_EN to add the {NV,OF,UF,NX} flags port.
module fp_mul_pipe
    import fp_mul_pipe_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] result,
    output logic [TAG_W-1:0]     out_tag
`ifdef FP_MUL_FLAGS_EN
    ,
    output logic [FLAG_W-1:0]    flags
`endif
);

    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int XW = EXP_W + 2;
    localparam int PW = 2 * MAN_W + 2;
    localparam logic signed [XW-1:0] BIAS_X    = XW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [XW-1:0] EXP_MAX_X = XW'((1 << EXP_W) - 1);
    localparam logic signed [XW-1:0] ONE_X     = XW'(1);
    localparam logic [W-1:0]         QNAN      = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    function automatic logic [MAN_W+1:0] round_rne(input logic [MAN_W:0] mant,
                                                   input logic guard, input logic sticky);
        return {1'b0, mant} + (MAN_W+2)'(guard & (sticky | mant[0]));
    endfunction

    function automatic logic [W-1:0] sat_pack(input logic sign, input logic signed [XW-1:0] exp_r,
                                              input logic [MAN_W-1:0] frac, input fp_special_e sp);
        case (sp)
            SP_NAN:  return QNAN;
            SP_INF:  return {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            SP_ZERO: return {sign, {(W-1){1'b0}}};
            default: ;
        endcase
        if (exp_r >= EXP_MAX_X)
            return {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        if (exp_r < ONE_X)
            return {sign, {(W-1){1'b0}}};
        return {sign, exp_r[EXP_W-1:0], frac};
    endfunction

    logic en;
    logic vld_p0, vld_p1, vld_p2, vld_p3;

    logic [W-1:0]     a_p0, b_p0;
    logic [TAG_W-1:0] tag_p0, tag_p1, tag_p2;

    logic                 sign_a, sign_b;
    logic [EXP_W-1:0]     exp_a, exp_b;
    logic [MAN_W:0]       sig_a, sig_b;
    logic [1:0]           cls_a, cls_b;
    logic signed [XW-1:0] exp_s1;
    logic [PW-1:0]        prod_s1;
    fp_special_e          sp_s1;

    logic                 sign_p1;
    logic signed [XW-1:0] exp_p1;
    logic [PW-1:0]        prod_p1;
    fp_special_e          sp_p1;

    logic signed [XW-1:0] exp_s2;
    logic [MAN_W:0]       mant_s2;
    logic                 guard_s2, sticky_s2;

    logic                 sign_p2;
    logic signed [XW-1:0] exp_p2;
    logic [MAN_W:0]       mant_p2;
    logic                 guard_p2, sticky_p2;
    fp_special_e          sp_p2;

    logic [MAN_W+1:0]     rnd_s3;
    logic                 carry_s3;
    logic [MAN_W-1:0]     frac_s3;
    logic signed [XW-1:0] exp_s3;
    logic [W-1:0]         res_s3;

    assign en        = !(vld_p3 && !out_ready);
    assign in_ready  = en;
    assign out_valid = vld_p3;

    // Stage 1: unpack registered operands, exponent sum, significand product
    fp_mul_pipe_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_a (
        .word(a_p0), .sign(sign_a), .exp(exp_a), .sig(sig_a), .cls(cls_a)
    );
    fp_mul_pipe_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_b (
        .word(b_p0), .sign(sign_b), .exp(exp_b), .sig(sig_b), .cls(cls_b)
    );

    assign exp_s1  = $signed(XW'(exp_a)) + $signed(XW'(exp_b)) - BIAS_X;
    assign prod_s1 = PW'(sig_a) * PW'(sig_b);
    assign sp_s1   = special_sel(cls_a, cls_b);

    // Stage 2: normalise product into [1,2), split off guard and sticky
    always_comb begin
        exp_s2    = exp_p1;
        mant_s2   = prod_p1[PW-2:MAN_W];
        guard_s2  = prod_p1[MAN_W-1];
        sticky_s2 = |prod_p1[MAN_W-2:0];
        if (prod_p1[PW-1]) begin
            exp_s2    = exp_p1 + ONE_X;
            mant_s2   = prod_p1[PW-1:MAN_W+1];
            guard_s2  = prod_p1[MAN_W];
            sticky_s2 = |prod_p1[MAN_W-1:0];
        end
    end

    // Stage 3: round, absorb mantissa carry, saturate/flush, pack
    assign rnd_s3   = round_rne(mant_p2, guard_p2, sticky_p2);
    assign carry_s3 = rnd_s3[MAN_W+1];
    assign frac_s3  = carry_s3 ? rnd_s3[MAN_W:1] : rnd_s3[MAN_W-1:0];
    assign exp_s3   = exp_p2 + XW'(carry_s3);
    assign res_s3   = sat_pack(sign_p2, exp_s3, frac_s3, sp_p2);

`ifdef FP_MUL_FLAGS_EN
    logic nv_s1, nv_p1, nv_p2;
    logic of_s3, uf_s3, nx_s3;

    assign nv_s1 = (cls_a == CLS_INF && cls_b == CLS_ZERO) || (cls_a == CLS_ZERO && cls_b == CLS_INF) ||
                   (cls_a == CLS_NAN && !a_p0[MAN_W-1]) || (cls_b == CLS_NAN && !b_p0[MAN_W-1]);
    assign of_s3 = (sp_p2 == SP_NONE) && (exp_s3 >= EXP_MAX_X);
    assign uf_s3 = (sp_p2 == SP_NONE) && (exp_s3 < ONE_X);
    assign nx_s3 = (sp_p2 == SP_NONE) && (guard_p2 || sticky_p2 || of_s3 || uf_s3);
`endif

    always_ff @(posedge clk) begin
        if (en) begin
            a_p0      <= a;
            b_p0      <= b;
            tag_p0    <= in_tag;
            sign_p1   <= sign_a ^ sign_b;
            exp_p1    <= exp_s1;
            prod_p1   <= prod_s1;
            sp_p1     <= sp_s1;
            tag_p1    <= tag_p0;
            sign_p2   <= sign_p1;
            exp_p2    <= exp_s2;
            mant_p2   <= mant_s2;
            guard_p2  <= guard_s2;
            sticky_p2 <= sticky_s2;
            sp_p2     <= sp_p1;
            tag_p2    <= tag_p1;
`ifdef FP_MUL_FLAGS_EN
            nv_p1     <= nv_s1;
            nv_p2     <= nv_p1;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0  <= 1'b0;
            vld_p1  <= 1'b0;
            vld_p2  <= 1'b0;
            vld_p3  <= 1'b0;
            result  <= '0;
            out_tag <= '0;
`ifdef FP_MUL_FLAGS_EN
            flags   <= '0;
`endif
        end else if (en) begin
            vld_p0  <= in_valid;
            vld_p1  <= vld_p0;
            vld_p2  <= vld_p1;
            vld_p3  <= vld_p2;
            result  <= res_s3;
            out_tag <= tag_p2;
`ifdef FP_MUL_FLAGS_EN
            flags   <= {nv_p2, of_s3, uf_s3, nx_s3};
`endif
        end
    end

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Scoreboard bench for fp_mul_pipe (binary32): directed corner cases, backpressure,
// mid-flight reset and randomized traffic against an integer-arithmetic reference model.
module tb_fp_mul_pipe;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int TAG_W = 4;
    localparam int W     = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     a, b;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     result;
    logic [TAG_W-1:0] out_tag;
`ifdef FP_MUL_FLAGS_EN
    logic [3:0]       flags;
`endif

    fp_mul_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .out_tag(out_tag)
`ifdef FP_MUL_FLAGS_EN
        , .flags(flags)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] res;
        logic [3:0]  flg;
        logic [3:0]  tag;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   rand_rdy = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Reference: exact integer product, then round-to-nearest-even by remainder comparison.
    function automatic logic [35:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
        int          ex, ey, e, sh;
        logic [63:0] mx, my, prod, q, rem, half;
        bit          zx, zy, ix, iy, nx, ny, s, nv, inexact;
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        zx = (ex == 0);
        zy = (ey == 0);
        ix = (ex == 255) && (x[22:0] == 0);
        iy = (ey == 255) && (y[22:0] == 0);
        nx = (ex == 255) && (x[22:0] != 0);
        ny = (ey == 255) && (y[22:0] != 0);
        s  = x[31] ^ y[31];
        if (nx || ny || (ix && zy) || (iy && zx)) begin
            nv = (ix && zy) || (iy && zx) || (nx && !x[22]) || (ny && !y[22]);
            return {nv, 3'b000, 32'h7FC00000};
        end
        if (ix || iy) return {4'b0000, s, 8'hFF, 23'd0};
        if (zx || zy) return {4'b0000, s, 31'd0};
        mx   = {40'd1, x[22:0]};
        my   = {40'd1, y[22:0]};
        prod = mx * my;
        e    = ex + ey - 127;
        sh   = 23;
        if (prod >= (64'd1 << 47)) begin
            sh = 24;
            e  = e + 1;
        end
        q    = prod >> sh;
        rem  = prod - (q << sh);
        half = 64'd1 << (sh - 1);
        if (rem > half || (rem == half && q[0])) q = q + 1;
        if (q == (64'd1 << 24)) begin
            q = q >> 1;
            e = e + 1;
        end
        inexact = (rem != 0);
        if (e >= 255) return {4'b0101, s, 8'hFF, 23'd0};
        if (e <= 0)   return {4'b0011, s, 31'd0};
        return {3'b000, inexact, s, e[7:0], q[22:0]};
    endfunction

    function automatic logic [31:0] rand_op();
        logic [31:0] r;
        logic        sg;
        r  = $urandom;
        sg = r[31];
        case ($urandom_range(0, 11))
            0: return {sg, 31'd0};
            1: return {sg, 8'h00, r[22:1], 1'b1};
            2: return {sg, 8'hFF, 23'd0};
            3: return {sg, 8'hFF, r[22:1], 1'b1};
            4: return {sg, 8'($urandom_range(190, 254)), r[22:0]};
            5: return {sg, 8'($urandom_range(1, 64)), r[22:0]};
            6: return {sg, 8'($urandom_range(100, 150)), 23'h7FFFFF - 23'($urandom_range(0, 3))};
            default: return {sg, 8'($urandom_range(64, 190)), r[22:0]};
        endcase
    endfunction

    task automatic send(input logic [31:0] x, input logic [31:0] y, input logic [3:0] t);
        logic [35:0] e;
        int          n;
        bit          ok;
        e        = ref_mul(x, y);
        in_valid = 1'b1;
        a        = x;
        b        = y;
        in_tag   = t;
        n        = 0;
        ok       = 1'b0;
        while (n < 200) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            n++;
        end
        if (!ok) chk("in_ready_timeout", 32'(in_ready), 32'd1);
        else sb_q.push_back('{res: e[31:0], flg: e[35:32], tag: t});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 1000) begin
            @(posedge clk);
            n++;
        end
        chk("drain_pending", 32'(sb_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic measure_latency(input string nm);
        int lat;
        lat = 0;
        while (!out_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk(nm, 32'(lat), 32'd3);
    endtask

    // Monitor: pops the scoreboard on each output transfer and checks stall stability.
    initial begin
        exp_t        e;
        bit          prev_stall;
        logic [31:0] prev_res;
        logic [3:0]  prev_tag;
        prev_stall = 1'b0;
        prev_res   = '0;
        prev_tag   = '0;
        forever begin
            @(negedge clk);
            if (prev_stall && !rst) begin
                chk("stall_valid", 32'(out_valid), 32'd1);
                chk("stall_result", result, prev_res);
                chk("stall_tag", 32'(out_tag), 32'(prev_tag));
            end
            prev_stall = out_valid && !out_ready && !rst;
            prev_res   = result;
            prev_tag   = out_tag;
            if (out_valid && out_ready && !rst) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_output", 32'(out_valid), 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("result", result, e.res);
                    chk("tag", 32'(out_tag), 32'(e.tag));
`ifdef FP_MUL_FLAGS_EN
                    chk("flags", 32'(flags), 32'(e.flg));
`endif
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    logic [31:0] dir_a [14] = '{32'h3F800000, 32'h40400000, 32'h3F800001, 32'h7F800000,
                                32'h7FC00000, 32'hFF800000, 32'h4F000000, 32'h7F000000,
                                32'h00800000, 32'h80400000, 32'h7F800001, 32'hC0000000,
                                32'h3F800001, 32'h3F800003};
    logic [31:0] dir_b [14] = '{32'h40000000, 32'h40400000, 32'h3F800001, 32'h00000000,
                                32'h3F800000, 32'h3F800000, 32'h4F000000, 32'h40000000,
                                32'h00800000, 32'h3F800000, 32'h3F800000, 32'h3F000000,
                                32'h3FC00000, 32'h3FC00000};
    logic [35:0] dir_e [14] = '{36'h0_40000000, 36'h0_41100000, 36'h1_3F800002, 36'h8_7FC00000,
                                36'h0_7FC00000, 36'h0_FF800000, 36'h0_5E800000, 36'h5_7F800000,
                                36'h3_00000000, 36'h0_80000000, 36'h8_7FC00000, 36'h0_BF800000,
                                36'h1_3FC00002, 36'h1_3FC00004};

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        in_tag    = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_result", result, 32'd0);
        chk("reset_out_tag", 32'(out_tag), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
`ifdef FP_MUL_FLAGS_EN
        chk("reset_flags", 32'(flags), 32'd0);
`endif

        // Directed table: expected values are independent constants, model agrees.
        for (int i = 0; i < 14; i++) begin
            chk("model_vs_table", 32'(ref_mul(dir_a[i], dir_b[i]) == dir_e[i]), 32'd1);
        end
        send(dir_a[0], dir_b[0], 4'd5);
        measure_latency("latency");
        drain();
        for (int i = 1; i < 14; i++) send(dir_a[i], dir_b[i], 4'(i));
        drain();

        // Backpressure: 8 back-to-back ops, consumer stalls in cycles 4..7.
        fork
            begin
                for (int i = 0; i < 8; i++) send(rand_op(), rand_op(), 4'(i + 8));
            end
            begin
                repeat (4) begin
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b0;
                repeat (4) begin
                    @(negedge clk);
                    chk("bp_in_ready_low", 32'(in_ready), 32'd0);
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with three ops in flight: none may emerge.
        for (int i = 0; i < 3; i++) send(32'h40000000, 32'h40400000, 4'(i + 1));
        rst = 1'b1;
        sb_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (6) begin
            chk("rst_no_output", 32'(out_valid), 32'd0);
            @(posedge clk);
            #1;
        end
        send(32'h40400000, 32'h40000000, 4'd9);
        measure_latency("latency_after_reset");
        drain();

        rand_rdy = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            send(rand_op(), rand_op(), 4'($urandom));
            if ($urandom_range(0, 7) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        rand_rdy = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
